// File: rtl/btn_pkg.sv
// Shared types and width helpers for the button event bank.
// Holds the per-channel FSM encoding and timer width calculations.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } btn_state_e;

    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DB_W   = $clog2(1000000);
    localparam int HOLD_W = $clog2(50000000);
    localparam int REP_W  = $clog2(10000000);

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, debounce, press/hold/repeat FSM
// and a wrapping press counter.
module btn_channel
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int DB_CYCLES     = 1000000,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 btn,
    input  logic                 repeat_en,
    input  logic                 cnt_clr,
    output logic                 level,
    output logic                 press_pulse,
    output logic                 release_pulse,
    output logic                 hold,
    output logic                 repeat_pulse,
    output logic [CNT_WIDTH-1:0] press_cnt
);

    localparam int DW = cw(DB_CYCLES);
    localparam int HW = cw(HOLD_CYCLES);
    localparam int RW = cw(REPEAT_CYCLES);

    logic [SYNC_STAGES-1:0] sr;
    logic                   sync;
    logic [DW-1:0]          db_cnt;
    logic [HW-1:0]          hold_t, hold_d;
    logic [RW-1:0]          rep_t, rep_d;
    btn_state_e             state_q, state_d;
    logic                   flip, rise, fall, rep_fire;

    assign sync = sr[SYNC_STAGES-1];
    assign flip = (sync != level) && (db_cnt == DW'(DB_CYCLES - 1));
    assign rise = flip && !level;
    assign fall = flip && level;
    assign hold = (state_q == HELD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr     <= '0;
            level  <= 1'b0;
            db_cnt <= '0;
        end else begin
            sr <= {sr[SYNC_STAGES-2:0], btn};
            if (sync == level) begin
                db_cnt <= '0;
            end else if (flip) begin
                level  <= ~level;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // A debounced fall is checked first so it beats a same-cycle repeat expiry.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_t;
        rep_d    = rep_t;
        rep_fire = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESSED;
                    hold_d  = '0;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_d = IDLE;
                end else if (hold_t == HW'(HOLD_CYCLES - 1)) begin
                    state_d = HELD;
                    rep_d   = '0;
                end else begin
                    hold_d = hold_t + 1'b1;
                end
            end
            HELD: begin
                if (fall) begin
                    state_d = IDLE;
                end else if (!repeat_en) begin
                    rep_d = '0;
                end else if (rep_t == RW'(REPEAT_CYCLES - 1)) begin
                    rep_fire = 1'b1;
                    rep_d    = '0;
                end else begin
                    rep_d = rep_t + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            hold_t        <= '0;
            rep_t         <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            press_cnt     <= '0;
        end else begin
            state_q       <= state_d;
            hold_t        <= hold_d;
            rep_t         <= rep_d;
            press_pulse   <= rise;
            release_pulse <= fall;
            repeat_pulse  <= rep_fire;
            if (cnt_clr) begin
                press_cnt <= '0;
            end else if (press_pulse || repeat_pulse) begin
                press_cnt <= press_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_event_bank.sv
// Multi-channel button front end; replicates btn_channel and packs
// the per-channel results into flat output vectors.
module btn_event_bank
    import btn_pkg::*;
#(
    parameter int NUM_BTN       = 3,
    parameter int SYNC_STAGES   = 2,
    parameter int DB_CYCLES     = 1000000,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic [NUM_BTN-1:0]           btn_in,
    input  logic [NUM_BTN-1:0]           repeat_en,
    input  logic [NUM_BTN-1:0]           cnt_clr,
    output logic [NUM_BTN-1:0]           level,
    output logic [NUM_BTN-1:0]           press_pulse,
    output logic [NUM_BTN-1:0]           release_pulse,
    output logic [NUM_BTN-1:0]           hold,
    output logic [NUM_BTN-1:0]           repeat_pulse,
    output logic [NUM_BTN*CNT_WIDTH-1:0] press_cnt
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .DB_CYCLES    (DB_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .CNT_WIDTH    (CNT_WIDTH)
        ) u_ch (
            .clk          (sys_clk),
            .rst_n        (sys_rst_n),
            .btn          (btn_in[i]),
            .repeat_en    (repeat_en[i]),
            .cnt_clr      (cnt_clr[i]),
            .level        (level[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i]),
            .hold         (hold[i]),
            .repeat_pulse (repeat_pulse[i]),
            .press_cnt    (press_cnt[i*CNT_WIDTH +: CNT_WIDTH])
        );
    end

endmodule

// File: tb/tb_btn_event_bank.sv
// Scoreboard bench for btn_event_bank with small timing parameters.
module tb_btn_event_bank;

    localparam int NB = 3;
    localparam int CW = 4;

    localparam int K_P  = 0;
    localparam int K_R  = 1;
    localparam int K_RP = 2;
    localparam int K_HD = 3;
    localparam int K_LV = 4;
    localparam int K_CN = 5;

    typedef struct {
        int cyc;
        int kind;
        int ch;
        int val;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [NB-1:0]    btn;
    logic [NB-1:0]    ren;
    logic [NB-1:0]    clr;
    logic [NB-1:0]    level;
    logic [NB-1:0]    press_pulse;
    logic [NB-1:0]    release_pulse;
    logic [NB-1:0]    hold;
    logic [NB-1:0]    repeat_pulse;
    logic [NB*CW-1:0] press_cnt;

    exp_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    btn_event_bank #(
        .NUM_BTN      (NB),
        .SYNC_STAGES  (2),
        .DB_CYCLES    (4),
        .HOLD_CYCLES  (20),
        .REPEAT_CYCLES(8),
        .CNT_WIDTH    (CW)
    ) dut (
        .sys_clk      (clk),
        .sys_rst_n    (rst_n),
        .btn_in       (btn),
        .repeat_en    (ren),
        .cnt_clr      (clr),
        .level        (level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .hold         (hold),
        .repeat_pulse (repeat_pulse),
        .press_cnt    (press_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_P:     return "press_pulse";
            K_R:     return "release_pulse";
            K_RP:    return "repeat_pulse";
            K_HD:    return "hold";
            K_LV:    return "level";
            default: return "press_cnt";
        endcase
    endfunction

    function automatic int val(input int k, input int ch);
        case (k)
            K_P:     return int'(press_pulse[ch]);
            K_R:     return int'(release_pulse[ch]);
            K_RP:    return int'(repeat_pulse[ch]);
            K_HD:    return int'(hold[ch]);
            K_LV:    return int'(level[ch]);
            default: return int'(press_cnt[ch*CW +: CW]);
        endcase
    endfunction

    function automatic void chk(input string name, input int ch,
                                input int act, input int want);
        n_tests++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s ch%0d cyc %0d: got %0d want %0d",
                     name, ch, cyc, act, want);
        end
    endfunction

    function automatic int find(input int c, input int k, input int ch);
        for (int i = 0; i < q.size(); i++)
            if (q[i].cyc == c && q[i].kind == k && q[i].ch == ch)
                return i;
        return -1;
    endfunction

    task automatic push(input int dc, input int k, input int ch, input int v);
        exp_t e;
        e.cyc  = cyc + dc;
        e.kind = k;
        e.ch   = ch;
        e.val  = v;
        q.push_back(e);
    endtask

    // Monitor: every pulse must match a queued expectation for this cycle;
    // level/hold/counter samples are compared when their cycle arrives.
    always @(negedge clk) begin
        int idx;
        for (int ch = 0; ch < NB; ch++) begin
            for (int k = K_P; k <= K_RP; k++) begin
                if (val(k, ch) == 1) begin
                    idx = find(cyc, k, ch);
                    n_tests++;
                    if (idx < 0) begin
                        n_fail++;
                        $display("FAIL %s ch%0d cyc %0d: got 1 want 0",
                                 kname(k), ch, cyc);
                    end else begin
                        q.delete(idx);
                    end
                end
            end
        end
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc && q[i].kind >= K_HD) begin
                chk(kname(q[i].kind), q[i].ch,
                    val(q[i].kind, q[i].ch), q[i].val);
                q.delete(i);
            end else if (q[i].cyc < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s ch%0d cyc %0d: got 0 want 1 (missed)",
                         kname(q[i].kind), q[i].ch, q[i].cyc);
                q.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        btn   = '0;
        ren   = '0;
        clr   = '0;
        repeat (3) @(negedge clk);
        chk("rst_level", 0, int'(level), 0);
        chk("rst_hold", 0, int'(hold), 0);
        chk("rst_pulses", 0,
            int'(press_pulse | release_pulse | repeat_pulse), 0);
        chk("rst_cnt", 0, int'(press_cnt), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // clean press with a long hold, no repeat
        push(6, K_P, 0, 0);
        push(6, K_LV, 0, 1);
        push(7, K_CN, 0, 1);
        push(26, K_HD, 0, 1);
        push(36, K_R, 0, 0);
        push(36, K_HD, 0, 0);
        push(36, K_LV, 0, 0);
        btn[0] = 1'b1;
        repeat (30) @(negedge clk);
        btn[0] = 1'b0;
        repeat (12) @(negedge clk);

        // bounce on ch1 never settles
        for (int i = 0; i < 6; i++) begin
            btn[1] = (i % 2 == 0);
            repeat (2) @(negedge clk);
        end
        btn[1] = 1'b0;
        push(10, K_LV, 1, 0);
        push(10, K_CN, 1, 0);
        repeat (14) @(negedge clk);

        // hold + auto-repeat, release collides with timer expiry
        ren[0] = 1'b1;
        push(6, K_P, 0, 0);
        push(26, K_HD, 0, 1);
        push(34, K_RP, 0, 0);
        push(35, K_CN, 0, 3);
        push(42, K_RP, 0, 0);
        push(50, K_RP, 0, 0);
        push(58, K_RP, 0, 0);
        push(66, K_R, 0, 0);
        push(66, K_HD, 0, 0);
        push(67, K_CN, 0, 6);
        btn[0] = 1'b1;
        repeat (60) @(negedge clk);
        btn[0] = 1'b0;
        repeat (12) @(negedge clk);
        ren[0] = 1'b0;

        // 16 presses on ch1 wrap the 4-bit counter
        for (int i = 0; i < 16; i++) begin
            push(6, K_P, 1, 0);
            push(7, K_CN, 1, (i + 1) % 16);
            push(14, K_R, 1, 0);
            btn[1] = 1'b1;
            repeat (8) @(negedge clk);
            btn[1] = 1'b0;
            repeat (8) @(negedge clk);
        end
        repeat (6) @(negedge clk);

        // simultaneous ch0/ch2 presses, ch1 untouched
        push(6, K_P, 0, 0);
        push(6, K_P, 2, 0);
        push(7, K_CN, 0, 7);
        push(7, K_CN, 2, 1);
        push(7, K_LV, 1, 0);
        push(7, K_CN, 1, 0);
        push(16, K_R, 0, 0);
        push(16, K_R, 2, 0);
        btn = 3'b101;
        repeat (10) @(negedge clk);
        btn = 3'b000;
        repeat (12) @(negedge clk);

        // clear beats a same-cycle increment
        push(6, K_P, 2, 0);
        push(7, K_CN, 2, 0);
        push(8, K_CN, 2, 0);
        push(16, K_R, 2, 0);
        btn[2] = 1'b1;
        repeat (6) @(negedge clk);
        clr[2] = 1'b1;
        @(negedge clk);
        clr[2] = 1'b0;
        repeat (3) @(negedge clk);
        btn[2] = 1'b0;
        repeat (12) @(negedge clk);

        // reset while ch0 is HELD, button kept down
        push(6, K_P, 0, 0);
        push(26, K_HD, 0, 1);
        push(29, K_HD, 0, 1);
        btn[0] = 1'b1;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_hold", 0, int'(hold[0]), 0);
        chk("midrst_level", 0, int'(level[0]), 0);
        chk("midrst_cnt", 0, int'(press_cnt), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push(6, K_P, 0, 0);
        push(7, K_CN, 0, 1);
        push(16, K_R, 0, 0);
        repeat (10) @(negedge clk);
        btn[0] = 1'b0;
        repeat (12) @(negedge clk);

        chk("sb_empty", 0, q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
